xalu_md_unit: RTL and testbench
===============================

Name: xalu_md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the ALU.
- Consumes the XALU_OP, HI_WE, LO_WE and XALUOUT_sel controls produced by the EX-stage control decoder.
- Executes mult/multu/div/divu/madd/maddu/msub/msubu with fixed latency and raises BUSY for the hazard unit.
- Returns HI or LO for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, BUSY cycles for mult/multu/madd/maddu/msub/msubu (must be >=1).
- DIV_CYCLES, 10, BUSY cycles for div/divu (must be >=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- XALU_OP  in  4  opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu; 9-15 treated as 0.
- A  in  32  rs operand, forwarded.
- B  in  32  rt operand, forwarded.
- HI_WE  in  1  mthi: HI <= A.
- LO_WE  in  1  mtlo: LO <= A.
- XALUOUT_sel  in  1  1 selects LO, 0 selects HI.
- XALU_OUT  out  32  combinational: XALUOUT_sel ? LO : HI (committed values).
- BUSY  out  1  operation in flight.

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, state=IDLE, counter=0, pending result discarded, BUSY=0.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- start = (XALU_OP in 1..8) && state==IDLE.
- On a start edge:
  - Latch the 64-bit result into pending {PH,PL}.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to MUL_RUN or DIV_RUN.
- In MUL_RUN/DIV_RUN: counter decrements each edge. On the edge where counter==1: {HI,LO} <= {PH,PL}, go to IDLE.
- Latency: op sampled at edge T0; BUSY=1 for exactly N cycles following T0 (N = MULT_CYCLES or DIV_CYCLES). New HI/LO are visible on XALU_OUT from the first cycle BUSY=0.
- BUSY = (state != IDLE), registered.
- XALU_OP nonzero while BUSY: ignored. The hazard unit must stall; this is not an error.
- HI_WE/LO_WE:
  - Take effect at the next edge only when state==IDLE and no start that cycle.
  - Ignored while BUSY.
  - If start and HI_WE/LO_WE coincide, start wins.
  - HI_WE and LO_WE together write A to both.
- Arithmetic:
  - mult: signed 32x32 -> 64; multu: unsigned.
  - madd/maddu: {HI,LO} + product, using HI/LO values at start; msub/msubu: minus product. All wrap modulo 2^64.
  - div: LO = quotient truncated toward zero; HI = remainder, sign of dividend. divu: unsigned.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, div/divu): runs full DIV_CYCLES with BUSY; HI/LO left unchanged at commit.
- XALU_OUT during BUSY returns the stale committed value. No bypass from the pending result.

Optional Feature:
- Macro XALU_CANCEL_EN.
- Defined: adds input CANCEL (1 bit, sampled at clk).
  - CANCEL=1 while BUSY: next edge returns to IDLE, BUSY=0, HI/LO unchanged, pending discarded.
  - CANCEL=1 with a start in the same cycle: suppresses the start.
  - Used for exception flush.
- Not defined: no CANCEL port; every started op always commits.

Decomposition:
- Shared package/header holds:
  - XALU_OP encodings: XOP_NONE=0 .. XOP_MSUBU=8.
  - State encodings: IDLE=0, MUL_RUN=1, DIV_RUN=2.
  - Defaults for MULT_CYCLES and DIV_CYCLES.
- One natural sub-module: xalu_md_datapath, a combinational 64-bit result calculator (A, B, op, HI, LO -> PH, PL, div0 flag). The FSM, counter and HI/LO registers stay in xalu_md_unit.

Test Plan:
- mult A=7, B=0xFFFFFFFD -> BUSY high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; XALU_OUT with sel=0/1 shows each.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE. A second op issued while BUSY is ignored; HI/LO reflect only the first.
- div A=0xFFFFFFF9 (-7), B=2 -> BUSY 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0, mtlo 0xFFFFFFFF, then madd 1*1 -> HI=1, LO=0. Then msub 1*1 -> HI=0, LO=0xFFFFFFFF.
- divu B=0 with HI=0x12, LO=0x34 -> BUSY 10 cycles, HI/LO unchanged. HI_WE asserted mid-BUSY is ignored.
- Reset asserted asynchronously in cycle 3 of a mult -> BUSY, HI and LO are 0 immediately, no later commit. With XALU_CANCEL_EN: CANCEL in cycle 2 of a div -> BUSY=0 next cycle, HI/LO keep prior values.

Source files
------------

// File: rtl/xalu_md_pkg.sv
// rtl/xalu_md_pkg.sv - shared opcodes, FSM states and latency defaults for xalu_md_unit
package xalu_md_pkg;

    typedef enum logic [3:0] {
        XOP_NONE  = 4'd0,
        XOP_MULT  = 4'd1,
        XOP_MULTU = 4'd2,
        XOP_DIV   = 4'd3,
        XOP_DIVU  = 4'd4,
        XOP_MADD  = 4'd5,
        XOP_MADDU = 4'd6,
        XOP_MSUB  = 4'd7,
        XOP_MSUBU = 4'd8
    } xalu_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } xalu_state_t;

    localparam int XALU_MULT_CYCLES_DEF = 5;
    localparam int XALU_DIV_CYCLES_DEF  = 10;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == XOP_DIV) || (op == XOP_DIVU);
    endfunction

endpackage

// File: rtl/xalu_md_datapath.sv
// rtl/xalu_md_datapath.sv - combinational 64-bit result for one multiply/divide/accumulate op
module xalu_md_datapath
    import xalu_md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] ph,
    output logic [31:0] pl,
    output logic        div0
);

    logic [63:0] prod_s, prod_u, acc, res;
    logic        signed_div, neg_a, neg_b;
    logic [31:0] mag_a, mag_b, dvsr, q_mag, r_mag, q, r;

    // low 64 bits of the sign-extended product equal the signed 64-bit product
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign acc    = {hi, lo};

    // signed divide on magnitudes, so 0x80000000 / -1 wraps cleanly to 0x80000000
    assign signed_div = (op == XOP_DIV);
    assign neg_a      = signed_div & a[31];
    assign neg_b      = signed_div & b[31];
    assign mag_a      = neg_a ? -a : a;
    assign mag_b      = neg_b ? -b : b;
    assign dvsr       = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag      = mag_a / dvsr;
    assign r_mag      = mag_a % dvsr;
    assign q          = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign r          = neg_a ? -r_mag : r_mag;

    assign div0 = is_div_op(op) && (b == 32'd0);

    always_comb begin
        res = acc;
        case (op)
            XOP_MULT:             res = prod_s;
            XOP_MULTU:            res = prod_u;
            XOP_MADD:             res = acc + prod_s;
            XOP_MADDU:            res = acc + prod_u;
            XOP_MSUB:             res = acc - prod_s;
            XOP_MSUBU:            res = acc - prod_u;
            XOP_DIV, XOP_DIVU:    res = {r, q};
            default:              res = acc;
        endcase
    end

    assign ph = res[63:32];
    assign pl = res[31:0];

endmodule

// File: rtl/xalu_md_unit.sv
// rtl/xalu_md_unit.sv - multi-cycle mul/div unit with HI/LO; optional flush input under XALU_CANCEL_EN
module xalu_md_unit
    import xalu_md_pkg::*;
#(
    parameter int MULT_CYCLES = XALU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = XALU_DIV_CYCLES_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  XALU_OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HI_WE,
    input  logic        LO_WE,
    input  logic        XALUOUT_sel,
`ifdef XALU_CANCEL_EN
    input  logic        CANCEL,
`endif
    output logic [31:0] XALU_OUT,
    output logic        BUSY
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    xalu_state_t   state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi, lo, ph, pl, dp_ph, dp_pl;
    logic          dp_div0, pend_div0, cancel, start, start_div;

`ifdef XALU_CANCEL_EN
    assign cancel = CANCEL;
`else
    assign cancel = 1'b0;
`endif

    assign start     = is_valid_op(XALU_OP) && (state == IDLE) && !cancel;
    assign start_div = is_div_op(XALU_OP);

    xalu_md_datapath u_datapath (
        .op   (XALU_OP),
        .a    (A),
        .b    (B),
        .hi   (hi),
        .lo   (lo),
        .ph   (dp_ph),
        .pl   (dp_pl),
        .div0 (dp_div0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            ph        <= '0;
            pl        <= '0;
            pend_div0 <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ph        <= dp_ph;
                        pl        <= dp_pl;
                        pend_div0 <= dp_div0;
                        cnt       <= start_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state     <= start_div ? DIV_RUN : MUL_RUN;
                        BUSY      <= 1'b1;
                    end else begin
                        if (HI_WE) hi <= A;
                        if (LO_WE) lo <= A;
                    end
                end
                MUL_RUN, DIV_RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else if (cnt == CW'(1)) begin
                        // a divide by zero runs its full latency but leaves HI/LO alone
                        if (!pend_div0) begin
                            hi <= ph;
                            lo <= pl;
                        end
                        state <= IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    assign XALU_OUT = XALUOUT_sel ? lo : hi;

endmodule

// File: tb/tb_xalu_md_unit.sv
// tb/tb_xalu_md_unit.sv - randomized self-checking bench for xalu_md_unit
module tb_xalu_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  xop;
    logic [31:0] opa, opb;
    logic        hi_we, lo_we, out_sel;
    logic [31:0] xout;
    logic        busy;
`ifdef XALU_CANCEL_EN
    logic        cancel;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    xalu_md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .XALU_OP     (xop),
        .A           (opa),
        .B           (opb),
        .HI_WE       (hi_we),
        .LO_WE       (lo_we),
        .XALUOUT_sel (out_sel),
`ifdef XALU_CANCEL_EN
        .CANCEL      (cancel),
`endif
        .XALU_OUT    (xout),
        .BUSY        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        out_sel = 1'b0; #1;
        check({tag, "_hi"}, xout, m_hi);
        out_sel = 1'b1; #1;
        check({tag, "_lo"}, xout, m_lo);
    endtask

    task automatic check_lit(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        out_sel = 1'b0; #1;
        check({tag, "_hi"}, xout, ehi);
        out_sel = 1'b1; #1;
        check({tag, "_lo"}, xout, elo);
    endtask

    // reference: results straight from 64-bit integer arithmetic
    task automatic model_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint               sp, sq, sr;
        longint unsigned      ux, uy, uq, ur;
        logic [63:0]          up, acc, r64;
        sp  = longint'($signed(x)) * longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        up  = ux * uy;
        acc = {m_hi, m_lo};
        r64 = acc;
        case (op)
            4'd1: r64 = sp;
            4'd2: r64 = up;
            4'd5: r64 = acc + sp;
            4'd6: r64 = acc + up;
            4'd7: r64 = acc - sp;
            4'd8: r64 = acc - up;
            4'd3: if (y != 0) begin
                sq  = longint'($signed(x)) / longint'($signed(y));
                sr  = longint'($signed(x)) % longint'($signed(y));
                r64 = {sr[31:0], sq[31:0]};
            end
            4'd4: if (y != 0) begin
                uq  = ux / uy;
                ur  = ux % uy;
                r64 = {ur[31:0], uq[31:0]};
            end
            default: r64 = acc;
        endcase
        m_hi = r64[63:32];
        m_lo = r64[31:0];
    endtask

    // called just after a falling edge; returns just after a falling edge
    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic hwe, input logic lwe);
        int n;
        logic [31:0] old_hi, old_lo;
        n = (op inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8}) ? MC :
            (op inside {4'd3, 4'd4}) ? DC : 0;
        xop = op; opa = x; opb = y; hi_we = hwe; lo_we = lwe;
        @(posedge clk);
        old_hi = m_hi;
        old_lo = m_lo;
        if (n > 0) model_op(op, x, y);
        else begin
            if (hwe) m_hi = x;
            if (lwe) m_lo = x;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("busy_run", busy, 1);
            out_sel = 1'($urandom_range(0, 1)); #1;
            check("stale_out", xout, out_sel ? old_lo : old_hi);
            xop   = 4'($urandom_range(1, 8));
            opa   = $urandom;
            opb   = $urandom;
            hi_we = 1'($urandom_range(0, 1));
            lo_we = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        xop = 4'd0; hi_we = 1'b0; lo_we = 1'b0;
        check("busy_done", busy, 0);
        check_out("result");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; xop = 4'd0; opa = '0; opb = '0;
        hi_we = 1'b0; lo_we = 1'b0; out_sel = 1'b0;
`ifdef XALU_CANCEL_EN
        cancel = 1'b0;
`endif
        m_hi = '0; m_lo = '0;
        #1;
        check("reset_busy", busy, 0);
        check_out("reset");
        #20;
        @(negedge clk);
        reset = 1'b0;

        do_op(4'd1, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
        check_lit("mult_lit", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check_lit("multu_lit", 32'h0000_0001, 32'hFFFF_FFFE);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check_lit("div_lit", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_lit("div_ovf_lit", 32'h0, 32'h8000_0000);
        do_op(4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        do_op(4'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        do_op(4'd5, 32'd1, 32'd1, 1'b0, 1'b0);
        check_lit("madd_lit", 32'd1, 32'd0);
        do_op(4'd7, 32'd1, 32'd1, 1'b0, 1'b0);
        check_lit("msub_lit", 32'd0, 32'hFFFF_FFFF);
        do_op(4'd0, 32'h12, 32'h0, 1'b1, 1'b0);
        do_op(4'd0, 32'h34, 32'h0, 1'b0, 1'b1);
        do_op(4'd4, 32'h5678, 32'h0, 1'b0, 1'b0);
        check_lit("divu0_lit", 32'h12, 32'h34);
        do_op(4'd9, 32'hDEAD_BEEF, 32'h3, 1'b0, 1'b0);
        do_op(4'd1, 32'h1234_5678, 32'h9, 1'b1, 1'b1);

        for (int k = 0; k < 60; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'h0 :
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            do_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the third busy cycle of a mult
        do_op(4'd0, 32'hA5A5_0001, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        xop = 4'd1; opa = 32'h7FFF_0003; opb = 32'h0001_0005;
        @(posedge clk);
        @(negedge clk);
        xop = 4'd0;
        check("rst_pre_busy1", busy, 1);
        @(negedge clk);
        check("rst_pre_busy2", busy, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        check("rst_async_busy", busy, 0);
        check_out("rst_async");
        @(negedge clk);
        reset = 1'b0;
        repeat (MC + 3) @(negedge clk);
        check("rst_after_busy", busy, 0);
        check_out("rst_no_commit");

`ifdef XALU_CANCEL_EN
        do_op(4'd0, 32'h0000_00AA, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        xop = 4'd3; opa = 32'd1000; opb = 32'd7;
        @(posedge clk);
        @(negedge clk);
        xop = 4'd0;
        check("cancel_busy1", busy, 1);
        @(negedge clk);
        check("cancel_busy2", busy, 1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_idle", busy, 0);
        check_out("cancel_keep");
        repeat (DC + 2) @(negedge clk);
        check("cancel_late_busy", busy, 0);
        check_out("cancel_no_commit");
        @(negedge clk);
        xop = 4'd1; opa = 32'd3; opb = 32'd3; cancel = 1'b1;
        @(negedge clk);
        xop = 4'd0; cancel = 1'b0;
        check("cancel_start_busy", busy, 0);
        repeat (MC + 1) @(negedge clk);
        check_out("cancel_start_keep");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
